// File: rtl/tournament_pkg.sv
// Shared types and saturating-counter helpers for the tournament branch predictor.
// Counter helpers take the counter width as an argument so one package serves every table.
package tournament_pkg;

   localparam int unsigned CTR_MAX_W     = 4;
   localparam int unsigned GHR_MAX_W     = 32;
   localparam int unsigned CTR_W_DEFAULT = 2;

   typedef logic [CTR_MAX_W-1:0] ctr_t;

   // Metadata travelling with a prediction from fetch to branch resolution.
   typedef struct packed {
      logic [GHR_MAX_W-1:0] ghr;
      logic                 global_pred;
      logic                 local_pred;
   } pred_meta_t;

   function automatic ctr_t ctr_max(input int unsigned ctr_w);
      return ctr_t'((5'd1 << ctr_w) - 5'd1);
   endfunction

   function automatic ctr_t ctr_rst_val(input int unsigned ctr_w);
      return ctr_t'((5'd1 << (ctr_w - 1)) - 5'd1);
   endfunction

   function automatic ctr_t sat_inc(input ctr_t value, input int unsigned ctr_w);
      return (value >= ctr_max(ctr_w)) ? value : value + 4'd1;
   endfunction

   function automatic ctr_t sat_dec(input ctr_t value, input int unsigned ctr_w);
      return (value == 4'd0) ? value : value - 4'd1;
   endfunction

   localparam ctr_t CTR_RST_DEFAULT = ctr_rst_val(CTR_W_DEFAULT);

endpackage

// File: rtl/sat_ctr_table.sv
// Table of 2^IDX_W saturating counters with one asynchronous read port and one
// update port that nudges a counter up or down by one.
module sat_ctr_table
   import tournament_pkg::*;
#(
   parameter int unsigned     IDX_W   = 12,
   parameter int unsigned     CTR_W   = 2,
   parameter logic [CTR_W-1:0] RST_VAL = CTR_W'(1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CTR_W-1:0] rd_val,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_dir
);

   logic [CTR_W-1:0] ctr_r [2**IDX_W];
   ctr_t             wide_s;
   logic [CTR_W-1:0] next_s;

   assign rd_val = ctr_r[rd_idx];

   // Next value of the counter being updated, saturating at both ends.
   always_comb begin
      wide_s = ctr_t'(ctr_r[upd_idx]);
      if (upd_dir) begin
         wide_s = sat_inc(ctr_t'(ctr_r[upd_idx]), CTR_W);
      end else begin
         wide_s = sat_dec(ctr_t'(ctr_r[upd_idx]), CTR_W);
      end
      next_s = wide_s[CTR_W-1:0];
   end

   // Counter storage with synchronous reset to the configured value.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2**IDX_W; i++) begin
            ctr_r[i] <= RST_VAL;
         end
      end else if (upd_en) begin
         ctr_r[upd_idx] <= next_s;
      end
   end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: gshare + two-level local + GHR-indexed chooser.
// Optional statistics counters are built when TOURNAMENT_STATS_EN is defined.
module tournament_predictor
   import tournament_pkg::*;
#(
   parameter int unsigned GHR_W     = 12,
   parameter int unsigned LHT_IDX_W = 10,
   parameter int unsigned LHIST_W   = 10,
   parameter int unsigned CTR_W     = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pred_valid,
   input  logic [31:0]      pred_pc,
   output logic             resp_valid,
   output logic             resp_taken,
   output logic [GHR_W-1:0] resp_ghr,
   output logic             resp_global,
   output logic             resp_local,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_global,
   input  logic             upd_local,
   input  logic             upd_mispredict
`ifdef TOURNAMENT_STATS_EN
   ,
   output logic [31:0]      stat_preds,
   output logic [31:0]      stat_mispred,
   output logic [31:0]      stat_local_sel
`endif
);

   localparam ctr_t             CTR_RST_WIDE = ctr_rst_val(CTR_W);
   localparam logic [CTR_W-1:0] CTR_RST      = CTR_RST_WIDE[CTR_W-1:0];

   logic [GHR_W-1:0]     ghr_r;
   logic [LHIST_W-1:0]   lht_r [2**LHT_IDX_W];

   logic [GHR_W-1:0]     pred_gidx_s;
   logic [LHT_IDX_W-1:0] pred_lidx_s;
   logic [LHIST_W-1:0]   pred_lhist_s;
   logic [GHR_W-1:0]     upd_gidx_s;
   logic [LHT_IDX_W-1:0] upd_lidx_s;
   logic [LHIST_W-1:0]   upd_lhist_s;

   logic [CTR_W-1:0]     gctr_s;
   logic [CTR_W-1:0]     lctr_s;
   logic [CTR_W-1:0]     cctr_s;
   logic                 pred_global_s;
   logic                 pred_local_s;
   logic                 pred_sel_local_s;
   logic                 pred_taken_s;
   logic                 chooser_en_s;
   logic                 chooser_dir_s;
   logic                 repair_s;

   logic                 resp_valid_r;
   logic                 resp_taken_r;
   pred_meta_t           resp_meta_r;

   assign pred_gidx_s  = pred_pc[GHR_W+1:2] ^ ghr_r;
   assign pred_lidx_s  = pred_pc[LHT_IDX_W+1:2];
   assign pred_lhist_s = lht_r[pred_lidx_s];
   assign upd_gidx_s   = upd_pc[GHR_W+1:2] ^ upd_ghr;
   assign upd_lidx_s   = upd_pc[LHT_IDX_W+1:2];
   assign upd_lhist_s  = lht_r[upd_lidx_s];
   assign repair_s     = upd_valid & upd_mispredict;

   sat_ctr_table #(.IDX_W(GHR_W), .CTR_W(CTR_W), .RST_VAL(CTR_RST)) u_global_pht (
      .clock   (clock),
      .reset   (reset),
      .rd_idx  (pred_gidx_s),
      .rd_val  (gctr_s),
      .upd_en  (upd_valid),
      .upd_idx (upd_gidx_s),
      .upd_dir (upd_taken)
   );

   sat_ctr_table #(.IDX_W(LHIST_W), .CTR_W(CTR_W), .RST_VAL(CTR_RST)) u_local_pht (
      .clock   (clock),
      .reset   (reset),
      .rd_idx  (pred_lhist_s),
      .rd_val  (lctr_s),
      .upd_en  (upd_valid),
      .upd_idx (upd_lhist_s),
      .upd_dir (upd_taken)
   );

   sat_ctr_table #(.IDX_W(GHR_W), .CTR_W(CTR_W), .RST_VAL(CTR_RST)) u_chooser (
      .clock   (clock),
      .reset   (reset),
      .rd_idx  (ghr_r),
      .rd_val  (cctr_s),
      .upd_en  (chooser_en_s),
      .upd_idx (upd_ghr),
      .upd_dir (chooser_dir_s)
   );

   // Component predictions and chooser selection; chooser trains only on disagreement.
   always_comb begin
      pred_global_s    = gctr_s[CTR_W-1];
      pred_local_s     = lctr_s[CTR_W-1];
      pred_sel_local_s = cctr_s[CTR_W-1];
      if (pred_sel_local_s) begin
         pred_taken_s = pred_local_s;
      end else begin
         pred_taken_s = pred_global_s;
      end
      chooser_en_s  = upd_valid & (upd_global ^ upd_local);
      chooser_dir_s = (upd_local == upd_taken);
   end

   // Speculative global history; a mispredict repair overrides the speculative shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         ghr_r <= {GHR_W{1'b0}};
      end else if (repair_s) begin
         ghr_r <= {upd_ghr[GHR_W-2:0], upd_taken};
      end else if (pred_valid) begin
         ghr_r <= {ghr_r[GHR_W-2:0], pred_taken_s};
      end
   end

   // Local history table, shifted with each resolved outcome.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2**LHT_IDX_W; i++) begin
            lht_r[i] <= {LHIST_W{1'b0}};
         end
      end else if (upd_valid) begin
         lht_r[upd_lidx_s] <= {upd_lhist_s[LHIST_W-2:0], upd_taken};
      end
   end

   // One-cycle registered prediction response.
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_valid_r <= 1'b0;
         resp_taken_r <= 1'b0;
         resp_meta_r  <= '{ghr: {GHR_MAX_W{1'b0}}, global_pred: 1'b0, local_pred: 1'b0};
      end else begin
         resp_valid_r <= pred_valid;
         if (pred_valid) begin
            resp_taken_r <= pred_taken_s;
            resp_meta_r  <= '{ghr: GHR_MAX_W'(ghr_r), global_pred: pred_global_s,
                              local_pred: pred_local_s};
         end
      end
   end

   assign resp_valid  = resp_valid_r;
   assign resp_taken  = resp_taken_r;
   assign resp_ghr    = resp_meta_r.ghr[GHR_W-1:0];
   assign resp_global = resp_meta_r.global_pred;
   assign resp_local  = resp_meta_r.local_pred;

`ifdef TOURNAMENT_STATS_EN
   logic [31:0] stat_preds_r;
   logic [31:0] stat_mispred_r;
   logic [31:0] stat_local_sel_r;

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_preds_r     <= 32'd0;
         stat_mispred_r   <= 32'd0;
         stat_local_sel_r <= 32'd0;
      end else begin
         if (pred_valid) begin
            stat_preds_r <= stat_preds_r + 32'd1;
         end
         if (repair_s) begin
            stat_mispred_r <= stat_mispred_r + 32'd1;
         end
         if (pred_valid && pred_sel_local_s) begin
            stat_local_sel_r <= stat_local_sel_r + 32'd1;
         end
      end
   end

   assign stat_preds     = stat_preds_r;
   assign stat_mispred   = stat_mispred_r;
   assign stat_local_sel = stat_local_sel_r;
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// Scoreboard bench for tournament_predictor: directed scenarios plus random traffic
// checked against an array-based reference model of the predictor rules.
module tb_tournament_predictor;

   localparam int GHR_W     = 12;
   localparam int LHT_IDX_W = 10;
   localparam int LHIST_W   = 10;
   localparam int CTR_W     = 2;
   localparam int GN        = 1 << GHR_W;
   localparam int LN        = 1 << LHT_IDX_W;
   localparam int HN        = 1 << LHIST_W;
   localparam int CMAX      = (1 << CTR_W) - 1;
   localparam int HALF      = 1 << (CTR_W - 1);
   localparam int CINIT     = HALF - 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             pred_valid;
   logic [31:0]      pred_pc;
   logic             resp_valid;
   logic             resp_taken;
   logic [GHR_W-1:0] resp_ghr;
   logic             resp_global;
   logic             resp_local;
   logic             upd_valid;
   logic [31:0]      upd_pc;
   logic             upd_taken;
   logic [GHR_W-1:0] upd_ghr;
   logic             upd_global;
   logic             upd_local;
   logic             upd_mispredict;
`ifdef TOURNAMENT_STATS_EN
   logic [31:0]      stat_preds;
   logic [31:0]      stat_mispred;
   logic [31:0]      stat_local_sel;
`endif

   always #5 clock = ~clock;

   tournament_predictor #(
      .GHR_W(GHR_W), .LHT_IDX_W(LHT_IDX_W), .LHIST_W(LHIST_W), .CTR_W(CTR_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .resp_valid     (resp_valid),
      .resp_taken     (resp_taken),
      .resp_ghr       (resp_ghr),
      .resp_global    (resp_global),
      .resp_local     (resp_local),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_ghr        (upd_ghr),
      .upd_global     (upd_global),
      .upd_local      (upd_local),
      .upd_mispredict (upd_mispredict)
`ifdef TOURNAMENT_STATS_EN
      ,
      .stat_preds     (stat_preds),
      .stat_mispred   (stat_mispred),
      .stat_local_sel (stat_local_sel)
`endif
   );

   typedef struct {
      bit taken;
      int ghr;
      bit g;
      bit l;
      bit sel;
   } exp_t;

   exp_t q[$];
   int   gpht[GN];
   int   lpht[HN];
   int   chs[GN];
   int   lht[LN];
   int   m_ghr;
   int   m_preds, m_mis, m_lsel;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int toward(input int v, input bit t);
      if (t) return (v < CMAX) ? v + 1 : v;
      return (v > 0) ? v - 1 : v;
   endfunction

   function automatic exp_t model_pred(input logic [31:0] pc);
      exp_t e;
      int gi, li;
      gi    = (int'(pc >> 2) & (GN - 1)) ^ m_ghr;
      li    = int'(pc >> 2) & (LN - 1);
      e.ghr = m_ghr;
      e.g   = gpht[gi] >= HALF;
      e.l   = lpht[lht[li]] >= HALF;
      e.sel = chs[m_ghr] >= HALF;
      e.taken = e.sel ? e.l : e.g;
      return e;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < GN; i++) begin
         gpht[i] = CINIT;
         chs[i]  = CINIT;
      end
      for (int i = 0; i < HN; i++) lpht[i] = CINIT;
      for (int i = 0; i < LN; i++) lht[i] = 0;
      m_ghr   = 0;
      m_preds = 0;
      m_mis   = 0;
      m_lsel  = 0;
   endfunction

   // Apply the current inputs to the model, push any expected response, advance one cycle.
   task automatic tick();
      exp_t e;
      int   gi, li, h;
      if (reset) begin
         model_reset();
      end else begin
         if (pred_valid) begin
            e = model_pred(pred_pc);
            q.push_back(e);
            m_preds++;
            if (e.sel) m_lsel++;
         end
         if (upd_valid) begin
            gi = (int'(upd_pc >> 2) & (GN - 1)) ^ int'(upd_ghr);
            li = int'(upd_pc >> 2) & (LN - 1);
            h  = lht[li];
            gpht[gi] = toward(gpht[gi], upd_taken);
            lpht[h]  = toward(lpht[h], upd_taken);
            lht[li]  = ((h << 1) | int'(upd_taken)) & (HN - 1);
            if (upd_global != upd_local)
               chs[int'(upd_ghr)] = toward(chs[int'(upd_ghr)], upd_local == upd_taken);
            if (upd_mispredict) m_mis++;
         end
         if (upd_valid && upd_mispredict)
            m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & (GN - 1);
         else if (pred_valid)
            m_ghr = ((m_ghr << 1) | int'(e.taken)) & (GN - 1);
      end
      @(posedge clock);
      #1;
      pred_valid = 1'b0;
      upd_valid  = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic set_pred(input logic [31:0] pc);
      pred_valid = 1'b1;
      pred_pc    = pc;
   endtask

   task automatic set_upd(input logic [31:0] pc, input bit t, input int gh,
                          input bit g, input bit l, input bit mis);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_taken      = t;
      upd_ghr        = GHR_W'(gh);
      upd_global     = g;
      upd_local      = l;
      upd_mispredict = mis;
   endtask

   task automatic check_stats(input string tag);
`ifdef TOURNAMENT_STATS_EN
      chk({tag, "_stat_preds"}, stat_preds, m_preds);
      chk({tag, "_stat_mispred"}, stat_mispred, m_mis);
      chk({tag, "_stat_local_sel"}, stat_local_sel, m_lsel);
`else
      if (tag.len() < 0) chk(tag, 0, 1);
`endif
   endtask

   // Monitor: pop the oldest expectation whenever the DUT presents a response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_resp", 1, 0);
            end else begin
               e = q.pop_front();
               chk("resp_taken", resp_taken, e.taken);
               chk("resp_ghr", resp_ghr, e.ghr);
               chk("resp_global", resp_global, e.g);
               chk("resp_local", resp_local, e.l);
            end
         end
      end
   end

   initial begin
      exp_t e;
      int   oldg;
      bit   t;
      reset = 1'b1; pred_valid = 1'b0; pred_pc = 32'h0;
      upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_ghr = '0;
      upd_global = 1'b0; upd_local = 1'b0; upd_mispredict = 1'b0;
      model_reset();
      #2;
      tick(); tick();
      reset = 1'b0;
      chk("reset_resp_valid", resp_valid, 0);
      check_stats("reset");

      // First prediction after reset.
      set_pred(32'h100); tick();
      chk("tp1_valid", resp_valid, 1);
      chk("tp1_taken", resp_taken, 0);
      chk("tp1_ghr", resp_ghr, 0);

      // Four taken updates saturate the global counter at index 0x40.
      repeat (4) begin set_upd(32'h100, 1'b1, 0, 1'b0, 1'b0, 1'b0); tick(); end
      set_pred(32'h100); tick();
      chk("tp2_global", resp_global, 1);
      chk("tp2_ghr", resp_ghr, 0);

      // Alternating pattern learned by the local predictor.
      for (int i = 0; i < 64; i++) begin
         t = (i % 2 == 0);
         e = model_pred(32'h200);
         set_pred(32'h200);
         set_upd(32'h200, t, e.ghr, e.g, e.l, 1'b0);
         tick();
         if (i >= 48) chk("tp3_local_pattern", resp_local, t);
      end

      // Mispredict repair discards speculative shifts.
      set_pred(32'h300); tick();
      set_pred(32'h304); tick();
      set_pred(32'h308); tick();
      set_upd(32'h300, 1'b1, 12'h005, 1'b0, 1'b1, 1'b1); tick();
      set_pred(32'h400); tick();
      chk("tp4_repaired_ghr", resp_ghr, 12'h00B);

      // Predict and repair in the same cycle.
      oldg = m_ghr;
      set_pred(32'h404);
      set_upd(32'h404, 1'b0, 12'h0A3, 1'b1, 1'b0, 1'b1);
      tick();
      chk("tp5_old_ghr", resp_ghr, oldg);
      set_pred(32'h408); tick();
      chk("tp5_new_ghr", resp_ghr, 12'h146);
      check_stats("mid");

      // Ten random cycles, then reset with traffic present.
      for (int i = 0; i < 10; i++) begin
         set_pred(32'h200 + 32'($urandom_range(0, 3) * 4));
         set_upd(32'h100, 1'($urandom_range(0, 1)), $urandom_range(0, GN - 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick();
      end
      reset = 1'b1;
      set_pred(32'h100);
      set_upd(32'h100, 1'b1, 0, 1'b0, 1'b1, 1'b1);
      tick();
      reset = 1'b0;
      chk("tp6_resp_valid_after_reset", resp_valid, 0);
      check_stats("tp6");
      set_pred(32'h100); tick();
      chk("tp6_global_reset", resp_global, 0);
      chk("tp6_ghr_reset", resp_ghr, 0);
      set_pred(32'h200); tick();
      chk("tp6_local_reset", resp_local, 0);

      // Random traffic over a small PC set so tables train and saturate.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) != 0)
            set_pred({$urandom_range(0, 15), 12'h000} | 32'($urandom_range(0, 31) * 4));
         if ($urandom_range(0, 2) != 0) begin
            upd_pc = {$urandom_range(0, 15), 12'h000} | 32'($urandom_range(0, 31) * 4);
            e = model_pred(upd_pc);
            set_upd(upd_pc, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, GN - 1) : e.ghr,
                    e.g, ($urandom_range(0, 4) == 0) ? ~e.l : e.l,
                    ($urandom_range(0, 7) == 0));
         end
         if ($urandom_range(0, 999) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
      end
      tick(); tick();
      check_stats("final");
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
